// File: rtl/mips_define.sv
// MIPS encoding constants and shared types for the instruction encoder.
// Holds the encode-class enum, FSM state enum and opcode/funct constants;
// every opcode value used by the encoder comes from here.
package mips_define;

    // Encoding class requested by the producer; code 7 is left undefined.
    typedef enum logic [2:0] {
        ENC_R       = 3'd0,
        ENC_I       = 3'd1,
        ENC_J       = 3'd2,
        ENC_LI      = 3'd3,
        ENC_NOP     = 3'd4,
        ENC_ERET    = 3'd5,
        ENC_SYSCALL = 3'd6
    } enc_kind_t;

    // IDLE accepts requests; LI_LO holds the LUI half of a two-word LI.
    typedef enum logic {
        IDLE  = 1'b0,
        LI_LO = 1'b1
    } enc_state_t;

    // Major opcodes (bits 31:26).
    localparam logic [5:0] OP_OTHER0 = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_Z0     = 6'h10;

    // COP0 "CO" bit (bit 25) selecting the coprocessor-operation form.
    localparam logic       OP_CO     = 1'b1;

    // SPECIAL funct codes and COP0 function codes (bits 5:0).
    localparam logic [5:0] OP0_SYSCALL = 6'h0C;
    localparam logic [5:0] OP0_ADDU    = 6'h21;
    localparam logic [5:0] OPC_ERET    = 6'h18;

    localparam logic [4:0] REG_ZERO  = 5'd0;

    // Result of encoding one request: first word, its last flag, and whether
    // a second (ORI) word must follow.
    typedef struct packed {
        logic [31:0] word;
        logic        last;
        logic        two_word;
    } enc_res_t;

endpackage

// File: rtl/inst_encoder.sv
// Encodes instruction requests into 32-bit MIPS words (LI may expand to LUI+ORI).
// Latency: one cycle from request acceptance to inst_valid; LI second word follows the first handshake.
// Backpressure: req_ready only in IDLE with a free or draining output register; outputs hold while stalled.
// Ports: clock/reset_n (async active-low); req_* valid/ready request channel;
//        inst_* valid/ready word channel with inst_last; words_out saturating handshake count.
module inst_encoder
    import mips_define::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_kind,
    input  logic [5:0]       req_op,
    input  logic [4:0]       req_rs,
    input  logic [4:0]       req_rt,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_shamt,
    input  logic [31:0]      req_imm,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_word,
    output logic             inst_last,
    output logic [CNT_W-1:0] words_out
);

    // Pure combinational encoder for the first (or only) word of a request.
    function automatic enc_res_t encode(
        input logic [2:0]  kind,
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [31:0] imm
    );
        enc_res_t r;
        r.word     = 32'h0000_0000;
        r.last     = 1'b1;
        r.two_word = 1'b0;
        case (enc_kind_t'(kind))
            ENC_R:       r.word = {OP_OTHER0, rs, rt, rd, shamt, op};
            ENC_I:       r.word = {op, rs, rt, imm[15:0]};
            ENC_J:       r.word = {op, imm[25:0]};
            ENC_LI: begin
                if (imm[31:16] != 16'h0000) begin
                    r.word     = {OP_LUI, REG_ZERO, rt, imm[31:16]};
                    r.last     = 1'b0;
                    r.two_word = 1'b1;
                end else begin
                    r.word     = {OP_ORI, REG_ZERO, rt, imm[15:0]};
                end
            end
            ENC_SYSCALL: r.word = {OP_OTHER0, 20'h00000, OP0_SYSCALL};
            ENC_ERET:    r.word = {OP_Z0, OP_CO, 19'h00000, OPC_ERET};
            // NOP and undefined codes both emit the all-zero word.
            default:     r.word = 32'h0000_0000;
        endcase
        return r;
    endfunction

    enc_state_t       state_q, state_d;
    logic             inst_valid_q, inst_valid_d;
    logic [31:0]      inst_word_q, inst_word_d;
    logic             inst_last_q, inst_last_d;
    logic [CNT_W-1:0] words_q, words_d;
    // Low half and rt of a two-word LI, captured at acceptance so the ORI word
    // does not depend on whatever the producer drives afterwards.
    logic [15:0]      lo_q, lo_d;
    logic [4:0]       rt_q, rt_d;

    enc_res_t         enc;
    logic             out_hs;
    logic             accept;

    always_comb begin
        enc = encode(req_kind, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm);

        out_hs = inst_valid_q && inst_ready;
        // Gated with reset_n so the producer sees "not ready" while in reset.
        req_ready = reset_n && (state_q == IDLE) && (!inst_valid_q || inst_ready);
        accept = req_valid && req_ready;

        state_d      = state_q;
        inst_valid_d = inst_valid_q;
        inst_word_d  = inst_word_q;
        inst_last_d  = inst_last_q;
        words_d      = words_q;
        lo_d         = lo_q;
        rt_d         = rt_q;

        if (out_hs) begin
            inst_valid_d = 1'b0;
            if (words_q != {CNT_W{1'b1}}) begin
                words_d = words_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    inst_valid_d = 1'b1;
                    inst_word_d  = enc.word;
                    inst_last_d  = enc.last;
                    if (enc.two_word) begin
                        state_d = LI_LO;
                        lo_d    = req_imm[15:0];
                        rt_d    = req_rt;
                    end
                end
            end
            LI_LO: begin
                // The ORI word replaces the LUI word only once LUI is taken.
                if (out_hs) begin
                    inst_valid_d = 1'b1;
                    inst_word_d  = {OP_ORI, rt_q, rt_q, lo_q};
                    inst_last_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            inst_valid_q <= 1'b0;
            inst_word_q  <= 32'h0000_0000;
            inst_last_q  <= 1'b0;
            words_q      <= '0;
            lo_q         <= 16'h0000;
            rt_q         <= 5'd0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_word_q  <= inst_word_d;
            inst_last_q  <= inst_last_d;
            words_q      <= words_d;
            lo_q         <= lo_d;
            rt_q         <= rt_d;
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_word  = inst_word_q;
    assign inst_last  = inst_last_q;
    assign words_out  = words_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: expected words are queued when a request is
// driven and compared by a negedge monitor at each output handshake.
module tb_inst_encoder;
    import mips_define::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [5:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [31:0] req_imm;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic        inst_last;
    logic [15:0] words_out;

    // Second instance with a 2-bit counter to observe saturation.
    logic        req_ready_s, inst_valid_s, inst_last_s;
    logic [31:0] inst_word_s;
    logic [1:0]  words_out_s;

    always #5 clock = ~clock;

    inst_encoder #(.CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word),
        .inst_last(inst_last), .words_out(words_out)
    );

    inst_encoder #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready_s), .req_kind(req_kind),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm),
        .inst_valid(inst_valid_s), .inst_ready(inst_ready), .inst_word(inst_word_s),
        .inst_last(inst_last_s), .words_out(words_out_s)
    );

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] kind, input logic [5:0] op,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh,
                         input logic [31:0] imm);
        req_valid = 1'b1;
        req_kind  = kind;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_shamt = sh;
        req_imm   = imm;
    endtask

    task automatic push(input logic [31:0] w, input logic l);
        exp_t e;
        e.word = w;
        e.last = l;
        sb.push_back(e);
    endtask

    // Output monitor: every handshake must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_word", inst_word, e.word);
                chk("out_last", 32'(inst_last), 32'(e.last));
            end
        end
    end

    logic [2:0]  b2b_kind [6];
    logic [5:0]  b2b_op   [6];
    logic [31:0] b2b_imm  [6];
    logic [31:0] b2b_word [6];

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_kind   = 3'd0;
        req_op     = 6'd0;
        req_rs     = 5'd0;
        req_rt     = 5'd0;
        req_rd     = 5'd0;
        req_shamt  = 5'd0;
        req_imm    = 32'd0;
        inst_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_last", 32'(inst_last), 32'd0);
        chk("rst_inst_word", inst_word, 32'h0000_0000);
        chk("rst_words_out", 32'(words_out), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("req_ready_after_reset", 32'(req_ready), 32'd1);

        // R-type ADDU $3,$1,$2
        inst_ready = 1'b1;
        drive(3'(ENC_R), OP0_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        push(32'h0022_1821, 1'b1);
        #1;
        chk("r_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("r_latency_valid", 32'(inst_valid), 32'd1);
        tick();
        #1;
        chk("r_valid_drop", 32'(inst_valid), 32'd0);
        chk("r_words", 32'(words_out), 32'd1);

        // Two-word LI; live inputs are scrambled after acceptance
        drive(3'(ENC_LI), 6'd0, 5'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        push(32'h3C05_1234, 1'b0);
        push(32'h34A5_5678, 1'b1);
        tick();
        req_valid = 1'b0;
        req_rt    = 5'd9;
        req_imm   = 32'hFFFF_FFFF;
        #1;
        chk("li_lo_req_ready", 32'(req_ready), 32'd0);
        chk("li_first_last", 32'(inst_last), 32'd0);
        tick();
        #1;
        chk("li_second_word", inst_word, 32'h34A5_5678);
        tick();
        #1;
        chk("li_words", 32'(words_out), 32'd3);
        chk("li_valid_drop", 32'(inst_valid), 32'd0);

        // Single-word LI
        drive(3'(ENC_LI), 6'd0, 5'd0, 5'd5, 5'd0, 5'd0, 32'h0000_BEEF);
        push(32'h3405_BEEF, 1'b1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("li1_last", 32'(inst_last), 32'd1);
        chk("li1_req_ready", 32'(req_ready), 32'd1);
        tick();
        #1;
        chk("li1_words", 32'(words_out), 32'd4);
        chk("sat_words_4", 32'(words_out_s), 32'd3);

        // ERET stalled for three cycles
        inst_ready = 1'b0;
        drive(3'(ENC_ERET), 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        push(32'h4200_0018, 1'b1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("eret_word_stable", inst_word, 32'h4200_0018);
            chk("eret_valid_held", 32'(inst_valid), 32'd1);
            chk("eret_req_ready", 32'(req_ready), 32'd0);
            chk("eret_words_hold", 32'(words_out), 32'd4);
            tick();
        end
        inst_ready = 1'b1;
        #1;
        chk("eret_ready_same_cycle", 32'(req_ready), 32'd1);
        tick();
        #1;
        chk("eret_words", 32'(words_out), 32'd5);
        chk("sat_words_5", 32'(words_out_s), 32'd3);

        // Back-to-back requests, one per cycle
        b2b_kind[0] = 3'(ENC_NOP);     b2b_op[0] = 6'd0;   b2b_imm[0] = 32'd0;          b2b_word[0] = 32'h0000_0000;
        b2b_kind[1] = 3'(ENC_SYSCALL); b2b_op[1] = 6'd0;   b2b_imm[1] = 32'd0;          b2b_word[1] = 32'h0000_000C;
        b2b_kind[2] = 3'd7;            b2b_op[2] = 6'h3F;  b2b_imm[2] = 32'hFFFF_FFFF;  b2b_word[2] = 32'h0000_0000;
        b2b_kind[3] = 3'(ENC_I);       b2b_op[3] = OP_ADDIU; b2b_imm[3] = 32'hFFFF_8001; b2b_word[3] = 32'h2464_8001;
        b2b_kind[4] = 3'(ENC_J);       b2b_op[4] = OP_J;   b2b_imm[4] = 32'h0123_4567;  b2b_word[4] = 32'h0923_4567;
        b2b_kind[5] = 3'(ENC_NOP);     b2b_op[5] = 6'd0;   b2b_imm[5] = 32'd0;          b2b_word[5] = 32'h0000_0000;
        for (int i = 0; i < 6; i++) begin
            drive(b2b_kind[i], b2b_op[i], 5'd3, 5'd4, 5'd0, 5'd0, b2b_imm[i]);
            push(b2b_word[i], 1'b1);
            #1;
            chk("b2b_req_ready", 32'(req_ready), 32'd1);
            tick();
        end
        req_valid = 1'b0;
        tick();
        #1;
        chk("b2b_words", 32'(words_out), 32'd11);
        chk("b2b_valid_drop", 32'(inst_valid), 32'd0);

        // Reset after the LUI handshake: the ORI word must be discarded
        drive(3'(ENC_LI), 6'd0, 5'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        push(32'h3C05_1234, 1'b0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("rst_li_lo_ready", 32'(req_ready), 32'd0);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_li_valid", 32'(inst_valid), 32'd0);
        chk("rst_li_words", 32'(words_out), 32'd0);
        chk("rst_li_req_ready", 32'(req_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post_rst_no_ori", 32'(inst_valid), 32'd0);
            tick();
        end
        chk("post_rst_words", 32'(words_out), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the emitted-word counter.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  an encode request is present.
REQ-005 SHALL have port req_ready  output  1  the request is accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_kind  input  3  encoding class (enc_kind_t).
REQ-007 SHALL have port req_op  input  6  funct for ENC_R; major opcode for ENC_I/ENC_J.
REQ-008 SHALL have ports req_rs, req_rt, req_rd, req_shamt  input  5 each  register and shift fields.
REQ-009 SHALL have port req_imm  input  32  immediate, jump index or LI constant.
REQ-010 SHALL have port inst_valid  output  1  inst_word holds an encoded instruction.
REQ-011 SHALL have port inst_ready  input  1  the consumer takes inst_word this cycle.
REQ-012 SHALL have port inst_word  output  32  encoded MIPS instruction.
REQ-013 SHALL have port inst_last  output  1  inst_word is the final word of its request.
REQ-014 SHALL have port words_out  output  CNT_W  count of completed output handshakes, saturating.

Function
REQ-015 ENC_R SHALL encode {OP_OTHER0, rs, rt, rd, shamt, req_op}.
REQ-016 ENC_I SHALL encode {req_op, rs, rt, req_imm[15:0]}; ENC_J SHALL encode {req_op, req_imm[25:0]}.
REQ-017 ENC_NOP SHALL encode 0x00000000; ENC_SYSCALL SHALL encode 0x0000000C; ENC_ERET SHALL encode {OP_Z0, OP_CO, 19'b0, OPC_ERET} = 0x42000018.
REQ-018 ENC_LI with req_imm[31:16]==0 SHALL emit one word, ORI rt,$0,imm[15:0], with inst_last=1.
REQ-019 ENC_LI with req_imm[31:16]!=0 SHALL emit LUI rt,imm[31:16] (inst_last=0) and then ORI rt,rt,imm[15:0] (inst_last=1).
REQ-020 Undefined req_kind codes SHALL encode as NOP with inst_last=1.
REQ-021 FSM states SHALL be IDLE and LI_LO; IDLE->LI_LO on acceptance of a two-word LI; LI_LO->IDLE when the LUI word handshakes, loading the ORI word.
REQ-022 The held low half and rt in LI_LO SHALL come from registers captured at acceptance, not from live request inputs.
REQ-023 req_ready SHALL equal (state==IDLE) && (!inst_valid || inst_ready); acceptance and output handshake SHALL be allowed in the same cycle.
REQ-024 Latency SHALL be one cycle: a request accepted at edge N gives inst_valid=1 after edge N.
REQ-025 While inst_valid && !inst_ready, inst_word and inst_last SHALL stay stable; an LI second word SHALL NOT be issued before the first handshakes.
REQ-026 inst_valid SHALL drop after a handshake unless a new word is loaded in the same cycle.
REQ-027 words_out SHALL increment by one per inst_valid&&inst_ready cycle and SHALL hold at all-ones.

Reset
REQ-028 When reset_n is low, state SHALL be IDLE; inst_valid, inst_last and words_out SHALL be 0; inst_word SHALL be 0x00000000. An LI pending in LI_LO SHALL be discarded.
REQ-029 During reset req_ready SHALL read 0; it SHALL read 1 in the first cycle after reset_n rises.

Structure
REQ-030 enc_kind_t (ENC_R=0, ENC_I, ENC_J, ENC_LI, ENC_NOP, ENC_ERET, ENC_SYSCALL) SHALL reside in mips_define; opcode constants SHALL come only from mips_define.
REQ-031 Encoding SHALL be a pure combinational function in the module; the output register plus FSM SHALL be the only sequential logic; no sub-module is required.

Verification
REQ-032 ENC_R op=OP0_ADDU rs=1 rt=2 rd=3 shamt=0 -> 0x00221821, inst_last=1, one cycle after accept.
REQ-033 ENC_LI rt=5 imm=0x12345678, inst_ready=1 -> 0x3C051234 (last=0), then 0x34A55678 (last=1); req_ready low in LI_LO; words_out+=2.
REQ-034 ENC_LI rt=5 imm=0x0000BEEF -> single word 0x3405BEEF, inst_last=1.
REQ-035 ENC_ERET with inst_ready low 3 cycles -> 0x42000018 held stable, req_ready=0, words_out unchanged until handshake.
REQ-036 Back-to-back ENC_NOP with inst_ready=1 -> one word per cycle, req_ready continuously 1.
REQ-037 Assert reset_n low while in LI_LO after LUI handshake -> inst_valid=0, ORI never emitted, words_out=0.
